// File: rtl/codes.sv
// Shared ALU opcode/funct codes and divider types; the divider FSM states live here with the rest.
// Combinational helpers only, no state; no flow control of its own.
package codes;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  localparam int          DIV_W         = 32;
  localparam int          DIV_CNT_W     = 5;
  localparam logic [4:0]  DIV_LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic [DIV_W-1:0] twos_neg(input logic [DIV_W-1:0] x);
    return ~x + {{(DIV_W-1){1'b0}}, 1'b1};
  endfunction

  // 0x80000000 maps onto itself, which the unsigned datapath reads as 2^31.
  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[DIV_W-1]) ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: 34 cycles from start to done_o (1 for a zero divisor).
// Backpressure: stall_o holds the issuing pipeline; starts outside IDLE are dropped, never queued.
module div_unit
  import codes::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  div_state_t           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     dvs_q;
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic                 done_q;
  logic [WIDTH-1:0]     quotient_q;
  logic [WIDTH-1:0]     remainder_q;

  logic [WIDTH:0]       shift_d;
  logic [WIDTH:0]       diff_d;
  logic                 fits_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quo_d;

  // One restoring step; the extra top bit keeps the carry out of the shifted remainder.
  always_comb begin
    shift_d = {rem_q, quo_q[WIDTH-1]};
    diff_d  = shift_d - {1'b0, dvs_q};
    fits_d  = ~diff_d[WIDTH];
    rem_d   = fits_d ? diff_d[WIDTH-1:0] : shift_d[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], fits_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            neg_quo_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_rem_q <= signed_i & dividend_i[WIDTH-1];
            quo_q     <= magnitude(dividend_i, signed_i);
            dvs_q     <= magnitude(divisor_i, signed_i);
            rem_q     <= '0;
            if (divisor_i == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend_i;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q   <= DIV_LAST_ITER;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          quotient_q  <= neg_quo_q ? twos_neg(quo_q) : quo_q;
          remainder_q <= neg_rem_q ? twos_neg(rem_q) : rem_q;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the ALU holds in the very cycle it issues; low in DONE so HI/LO can be captured.
  assign stall_o     = ((state_q == IDLE) && start_i) || (state_q == CALC) || (state_q == FIX);
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit divider executing MIPS DIV and DIVU on behalf of the ALU. The ALU issues a one-cycle start request with rs/rt operands and holds the pipeline while `stall_o` is high. `div_unit` returns quotient (LO) and remainder (HI) with a one-cycle `done_o` pulse, and the ALU writes them into its HI/LO register. It is the producer side of the ALU's `stall_o` and HI/LO write path, which MULT/MULTU currently drive alone.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request; accepted only in IDLE.
- `signed_i`  in  1  1 = DIV, 0 = DIVU; sampled with `start_i`.
- `dividend_i`  in  32  rs; sampled with `start_i`.
- `divisor_i`  in  32  rt; sampled with `start_i`.
- `stall_o`  out  1  pipeline hold request.
- `done_o`  out  1  one-cycle pulse; results valid and written to HI/LO.
- `quotient_o`  out  32  LO value; registered, held until the next completion.
- `remainder_o`  out  32  HI value; registered, held until the next completion.

## Operation
- States (`div_state_t`):
  - IDLE: waits for a request.
  - CALC: 32 iterations.
  - FIX: sign correction and result register load.
  - DONE: `done_o` = 1.
- IDLE with `start_i` = 1:
  - Latches operands and `signed_i`.
  - Computes magnitudes: two's-complement absolute value when signed, raw value when unsigned.
  - Records `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend). Both are 0 when unsigned.
  - Loads the iteration counter with 31.
  - Goes to CALC, except for a zero divisor (see below).
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by one, bringing in the next dividend bit.
  - If rem ≥ |divisor|, subtract and set the quotient bit.
  - Use a 33-bit compare/subtract so no carry is lost.
  - Counter decrements each cycle. On the counter-0 cycle, go to FIX.
- FIX:
  - `quotient_o` = `neg_q` ? −quo : quo.
  - `remainder_o` = `neg_r` ? −rem : rem.
  - Go to DONE.
- DONE: `done_o` = 1 for exactly this cycle, then go to IDLE.
- Divide by zero (divisor = 0, either mode):
  - No iteration: IDLE goes directly to DONE.
  - `quotient_o` = 0xFFFFFFFF, `remainder_o` = dividend unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): falls out of the magnitude path with no special case; quotient 0x80000000, remainder 0.
- Remainder sign always follows the dividend; |remainder| < |divisor|.
- `start_i` outside IDLE is ignored. No queuing, no error.
- `start_i` and `reset` together: reset wins.
- Reset in any state:
  - Next state IDLE, counter 0.
  - `quotient_o` = 0, `remainder_o` = 0, `done_o` = 0.
  - Any in-flight division is discarded.

## Timing
- Edge E0 samples `start_i`.
- Nonzero divisor:
  - CALC occupies edges E1..E32; FIX is at E33.
  - `done_o` = 1 in the cycle after E33, with results valid in the same cycle.
  - Next start is accepted at edge E35 at the earliest. A start presented in the DONE cycle (sampled at E34) is ignored.
- Zero divisor: `done_o` = 1 in the cycle after E0. Next start is accepted at E2.
- `stall_o` = (IDLE and `start_i`) or CALC or FIX.
  - It is combinational, so the pipeline holds in the issuing cycle.
  - It is low in the DONE cycle so the ALU captures HI/LO there.
- Reset values:
  - `stall_o` = 0 once `start_i` = 0.
  - `done_o` = 0, `quotient_o` = 0, `remainder_o` = 0.

## Structure
- Add `div_state_t` (IDLE, CALC, FIX, DONE) to package `codes`.
- Reuse `FUNC_DIV`/`FUNC_DIVU` from `codes`. The ALU derives `start_i` = (opcode == OP_SPECIAL && funct ∈ {FUNC_DIV, FUNC_DIVU} && !busy) and `signed_i` = (funct == FUNC_DIV).
- No sub-module: the FSM, one 33-bit subtractor and two output negators fit in one module.
- ALU integration:
  - OR `stall_o` into the ALU stall.
  - Load mf_q with {`remainder_o`, `quotient_o`} on `done_o`.

## Test plan
- DIVU 100 / 7 → `done_o` pulse after E33; quotient 14, remainder 2; `stall_o` high from the start cycle through the FIX cycle.
- DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU same operands → quotient 0, remainder 0x80000000.
- DIVU 0x12345678 / 0 → `done_o` in the cycle after E0; quotient 0xFFFFFFFF, remainder 0x12345678; `stall_o` high for one cycle only.
- Start DIVU 100/7, assert `start_i` again at E5 with other operands, then assert `reset` for one cycle at E10.
  - The E5 start is ignored.
  - After reset: state IDLE, outputs 0, no `done_o`.
  - A fresh 9 / 3 request then yields quotient 3, remainder 0.
- Back-to-back DIVU 0xFFFFFFFF / 1 then 0xFFFFFFFF / 0xFFFFFFFF, second start at E35 → quotient 0xFFFFFFFF, remainder 0, then quotient 1, remainder 0; `quotient_o` holds between pulses.
